// File: rtl/fetch_pkg.sv
// Shared constants, FIFO entry layout and FSM encoding for the instruction fetch unit.
package fetch_pkg;
   localparam int XLEN       = 64;
   localparam int INST_BYTES = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// First-word fall-through prefetch queue with synchronous flush.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 128,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_data,
   output logic [CW-1:0]    o_count
);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push && !i_flush && (r_count != FULL);
   assign w_pop  = i_pop && !i_flush && (r_count != '0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   // Storage is not reset, so an empty queue presents zeros instead of stale data.
   assign o_head_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign o_count     = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher: one outstanding memory read, prefetch queue, redirect flush.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);
   localparam int              CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic            w_push;
   logic            w_flush;
   logic            w_pop;
   logic [CW-1:0]   w_count;
   logic [CW-1:0]   w_cnt_after;
   fetch_entry_t    w_push_entry;
   fetch_entry_t    w_head;

   assign w_pop       = inst_valid && inst_ready;
   assign w_cnt_after = w_count + CW'(1) - CW'(w_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_push      = 1'b0;
      w_flush     = 1'b0;
      case (r_state)
         S_IDLE: if (w_count < FULL) w_state_nxt = S_REQ;
         S_REQ: begin
            if (mem_ack) begin
               w_push      = 1'b1;
               w_pc_nxt    = r_pc + PC_STEP;
               w_state_nxt = (w_cnt_after < FULL) ? S_REQ : S_IDLE;
            end
         end
         S_DROP: if (mem_ack) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      // A redirect discards everything in flight; an unanswered request must still be drained.
      if (redirect_valid) begin
         w_flush  = 1'b1;
         w_push   = 1'b0;
         w_pc_nxt = {redirect_pc[XLEN-1:3], 3'b000};
         case (r_state)
            S_REQ:   w_state_nxt = mem_ack ? S_IDLE : S_DROP;
            S_DROP:  w_state_nxt = mem_ack ? S_IDLE : S_DROP;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign w_push_entry = '{data: mem_rdata, pc: r_pc};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_flush     (w_flush),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_head_data (w_head),
      .o_count     (w_count)
   );

   assign mem_req    = (r_state == S_REQ);
   assign mem_addr   = r_pc;
   assign inst_valid = (w_count != '0);
   assign inst_data  = w_head.data;
   assign inst_pc    = w_head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, PC wrap and reset abandon.
module tb_fetch_unit;
   logic        clk;
   logic        reset;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic        inst_valid;
   logic [63:0] inst_data;
   logic [63:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.RESET_PC(64'h0), .DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT one cycle after release, i.e. in REQ at RESET_PC.
   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   // Expects a request at addr, holds it dly cycles, then acks with data for one cycle.
   task automatic serve(input string tag, input logic [63:0] addr, input logic [63:0] data,
                        input int dly);
      chk({tag, "_req"}, {63'd0, mem_req}, 64'd1);
      chk({tag, "_addr"}, mem_addr, addr);
      for (int i = 0; i < dly; i++) step();
      if (dly > 0) chk({tag, "_addr_hold"}, mem_addr, addr);
      mem_ack   = 1'b1;
      mem_rdata = data;
      step();
      mem_ack   = 1'b0;
      mem_rdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      step();
      step();
      chk("rst_req",   {63'd0, mem_req},    64'd0);
      chk("rst_addr",  mem_addr,            64'h0);
      chk("rst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rst_data",  inst_data,           64'h0);
      chk("rst_pc",    inst_pc,             64'h0);
      reset = 1'b0;
      step();
      chk("rel_req_first", {63'd0, mem_req}, 64'd1);

      // Streaming with two-cycle memory latency and a consuming CPU.
      inst_ready = 1'b1;
      serve("s0", 64'h0, 64'h1111_0000_0000_0000, 2);
      chk("s0_valid", {63'd0, inst_valid}, 64'd1);
      chk("s0_ipc", inst_pc, 64'h0);
      chk("s0_data", inst_data, 64'h1111_0000_0000_0000);
      serve("s1", 64'h8, 64'h2222_0000_0000_0008, 2);
      chk("s1_ipc", inst_pc, 64'h8);
      chk("s1_data", inst_data, 64'h2222_0000_0000_0008);
      serve("s2", 64'h10, 64'h3333_0000_0000_0010, 2);
      chk("s2_ipc", inst_pc, 64'h10);
      chk("s2_data", inst_data, 64'h3333_0000_0000_0010);

      // Back-pressure: queue fills after four immediate acks.
      inst_ready = 1'b0;
      do_reset();
      serve("f0", 64'h00, 64'hA0, 0);
      serve("f1", 64'h08, 64'hA1, 0);
      serve("f2", 64'h10, 64'hA2, 0);
      serve("f3", 64'h18, 64'hA3, 0);
      chk("full_req", {63'd0, mem_req}, 64'd0);
      step();
      chk("full_req_hold", {63'd0, mem_req}, 64'd0);
      chk("full_head_pc", inst_pc, 64'h0);
      chk("full_head_data", inst_data, 64'hA0);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("pop1_req", {63'd0, mem_req}, 64'd0);
      chk("pop1_head", inst_pc, 64'h8);
      step();
      chk("refill_req", {63'd0, mem_req}, 64'd1);
      chk("refill_addr", mem_addr, 64'h20);
      step();
      serve("f4", 64'h20, 64'hA4, 0);
      chk("refill_once", {63'd0, mem_req}, 64'd0);
      inst_ready = 1'b1;
      chk("drain0", inst_pc, 64'h08);
      step();
      chk("drain1", inst_pc, 64'h10);
      step();
      chk("drain2", inst_pc, 64'h18);
      step();
      chk("drain3", inst_pc, 64'h20);
      chk("drain3_data", inst_data, 64'hA4);
      step();
      chk("drained", {63'd0, inst_valid}, 64'd0);

      // Redirect while 0x18 is pending; the late ack must be discarded.
      do_reset();
      serve("r0", 64'h00, 64'hB0, 0);
      serve("r1", 64'h08, 64'hB1, 0);
      serve("r2", 64'h10, 64'hB2, 0);
      chk("r_pending", mem_addr, 64'h18);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h1003;
      step();
      redirect_valid = 1'b0;
      chk("drop_req", {63'd0, mem_req}, 64'd0);
      chk("drop_flush", {63'd0, inst_valid}, 64'd0);
      step();
      step();
      mem_ack   = 1'b1;
      mem_rdata = 64'hDEAD;
      step();
      mem_ack   = 1'b0;
      chk("drop_nopush", {63'd0, inst_valid}, 64'd0);
      chk("drop_idle", {63'd0, mem_req}, 64'd0);
      step();
      serve("rd", 64'h1000, 64'hC0, 1);
      chk("rd_ipc", inst_pc, 64'h1000);
      chk("rd_data", inst_data, 64'hC0);

      // Redirect coinciding with an ack and a pop.
      mem_ack        = 1'b1;
      mem_rdata      = 64'hDEAD;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h2000;
      step();
      mem_ack        = 1'b0;
      redirect_valid = 1'b0;
      chk("co_empty", {63'd0, inst_valid}, 64'd0);
      chk("co_idle", {63'd0, mem_req}, 64'd0);
      step();
      serve("co", 64'h2000, 64'hC1, 0);
      chk("co_ipc", inst_pc, 64'h2000);

      // PC wrap at the top of the address space; low bits of redirect_pc ignored.
      mem_ack        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      mem_ack        = 1'b0;
      redirect_valid = 1'b0;
      step();
      serve("wr", 64'hFFFF_FFFF_FFFF_FFF8, 64'hE0, 0);
      chk("wrap_addr", mem_addr, 64'h0);
      chk("wrap_ipc", inst_pc, 64'hFFFF_FFFF_FFFF_FFF8);

      // Reset while in REQ, then a stale ack while IDLE.
      inst_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("arst_req", {63'd0, mem_req}, 64'd0);
      chk("arst_valid", {63'd0, inst_valid}, 64'd0);
      step();
      reset = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 64'hBEEF;
      step();
      mem_ack   = 1'b0;
      chk("late_nopush", {63'd0, inst_valid}, 64'd0);
      chk("late_req", {63'd0, mem_req}, 64'd1);
      chk("late_addr", mem_addr, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
